ascon_perm_engine: RTL and testbench
====================================

# ascon_perm_engine

Iterative ASCON-p permutation engine: the responder side of the round handshake driven by the AEAD phase controller. On an accepted `round_start` it loads a 320-bit state, applies `total_rounds` ASCON rounds (one per cycle by default), reports `busy` while working and pulses `round_done` with the result on `state_out`. It sits between the phase controller and the AEAD datapath's state register.

## Interface
- Parameters: none. Widths and constants come from `ascon_pkg`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-low.
- `round_start`  in  1  permutation request. Level-tolerant; sampled only in IDLE.
- `enable`  in  1  round advance permission. Low during RUN stalls the engine.
- `total_rounds`  in  4  number of rounds N, sampled with `round_start`.
- `state_in`  in  320  input state, sampled with `round_start`. Word layout: x0=[319:256], x1=[255:192], x2=[191:128], x3=[127:64], x4=[63:0].
- `state_out`  out  320  working/result state register. Valid when `round_done`=1.
- `busy`  out  1  high in RUN.
- `round_done`  out  1  one-cycle pulse in DONE.

## Operation
- The FSM has three states:
  - IDLE → RUN when `round_start`=1.
  - RUN → DONE after the last round.
  - DONE → IDLE unconditionally.
- Accept in IDLE:
  - `state_out` ← `state_in`.
  - `rnd_idx` ← 12−N.
  - `rnd_left` ← N.
- N rules:
  - N>12 saturates to 12.
  - N=0 goes IDLE → DONE directly with `state_out`=`state_in` unmodified.
- Each RUN cycle with `enable`=1 applies one round to `state_out`, then `rnd_idx`+1 and `rnd_left`−1. When `rnd_left` reaches 0 the FSM moves to DONE.
- With `enable`=0 in RUN, the state, counters and FSM all hold. `busy` stays 1.
- Round, applied in order:
  - Constant addition: x2[7:0] ^= RC[rnd_idx]. RC = F0,E1,D2,C3,B4,A5,96,87,78,69,5A,4B.
  - 5-bit S-box layer across x0..x4 bit-slices (ASCON S-box).
  - Linear layer, right rotates: x0 ^= ror19 ^ ror28; x1 ^= ror61 ^ ror39; x2 ^= ror1 ^ ror6; x3 ^= ror10 ^ ror17; x4 ^= ror7 ^ ror41.
- `round_start` in RUN or DONE is ignored. A controller holding it high across phases is re-accepted on the IDLE cycle after DONE.
- `state_out` holds its value in IDLE and DONE.

## Timing
- Reset values: FSM=IDLE, `busy`=0, `round_done`=0, `state_out`=0, counters=0.
- Reset asserted mid-RUN aborts at the next edge. No `round_done` is produced.
- Latency, default build, `enable` held 1:
  - Accept at edge 0.
  - RUN for cycles 1..N.
  - `round_done`=1 in cycle N+1.
  - Earliest re-accept is cycle N+2.
- N=12 gives `round_done` 13 cycles after acceptance. N=6 gives 7.
- Each `enable`=0 cycle in RUN adds exactly one cycle of latency.
- `busy` and `round_done` are never high together.

## Configuration
- `ASCON_PERM_UNROLL2_EN`:
  - Defined: two chained rounds per RUN cycle. If one round remains, the last cycle applies one round. RUN lasts ceil(N/2) cycles, so `round_done` arrives in cycle ceil(N/2)+1.
  - Undefined: one round per cycle as above.
- Results must be bit-identical in both builds.

## Structure
- `ascon_pkg` holds:
  - `ASCON_STATE_W`=320 and `ASCON_MAX_ROUNDS`=12.
  - The RC constant array.
  - The `perm_state_t` enum {IDLE, RUN, DONE}.
  - The 64-bit `ror64` function.
- Sub-module `ascon_round_fn`: purely combinational single round with inputs (state, `rnd_idx`) and output the next state. It is instantiated once, or twice chained under the macro.

## Test plan
- All-zero `state_in`, N=12, `enable`=1 → `busy` high for cycles 1–12; `round_done` in cycle 13; `state_out` equals the C-reference p12(0).
- ASCON-128 init state (IV 80400C0600000000, K=N=000102…0F), N=12 → matches the reference init output; then N=6 on that result → matches p6.
- `enable` low for 3 cycles in mid-RUN with N=12 → `round_done` in cycle 16; same `state_out` as the unstalled run.
- N=0 → `round_done` in cycle 1 with `state_out`=`state_in`. N=15 → identical to N=12.
- `round_start` held high across 2 requests → second accept in cycle N+2; pulses in RUN are ignored.
- Reset asserted in cycle 5 of N=12 → next cycle `busy`=0, `round_done`=0, `state_out`=0; no `round_done` follows.

Source files
------------

// File: rtl/ascon_pkg.sv
// Shared widths, round constants, FSM encoding and rotate helper for the ASCON permutation engine.
package ascon_pkg;

  localparam int ASCON_STATE_W    = 320;
  localparam int ASCON_MAX_ROUNDS = 12;

  localparam logic [7:0] ASCON_RC [ASCON_MAX_ROUNDS] = '{
    8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
  };

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } perm_state_t;

  // Amounts are always 1..63 in the linear layer, so both shifts stay in range.
  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_perm_engine_if.sv
// Round handshake between the AEAD phase controller (master) and the permutation engine (slave).
interface ascon_perm_engine_if;
  import ascon_pkg::*;

  logic                     round_start;
  logic                     enable;
  logic [3:0]               total_rounds;
  logic [ASCON_STATE_W-1:0] state_in;
  logic [ASCON_STATE_W-1:0] state_out;
  logic                     busy;
  logic                     round_done;

  modport master (
    output round_start, enable, total_rounds, state_in,
    input  state_out, busy, round_done
  );

  modport slave (
    input  round_start, enable, total_rounds, state_in,
    output state_out, busy, round_done
  );

endinterface

// File: rtl/ascon_round_fn.sv
// One combinational ASCON round: constant addition, bit-sliced S-box, linear diffusion.
module ascon_round_fn
  import ascon_pkg::*;
(
  input  logic [ASCON_STATE_W-1:0] state,
  input  logic [3:0]               rnd_idx,
  output logic [ASCON_STATE_W-1:0] next_state
);

  logic [7:0]  rc;
  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] b0, b1, b2, b3, b4;
  logic [63:0] c0, c1, c2, c3, c4;
  logic [63:0] d0, d1, d2, d3, d4;

  // An index past the table only occurs on the unused second stage of the unrolled build.
  assign rc = (rnd_idx < 4'(ASCON_MAX_ROUNDS)) ? ASCON_RC[rnd_idx] : 8'h00;

  assign x0 = state[319:256];
  assign x1 = state[255:192];
  assign x2 = state[191:128] ^ {56'h0, rc};
  assign x3 = state[127:64];
  assign x4 = state[63:0];

  assign a0 = x0 ^ x4;
  assign a1 = x1;
  assign a2 = x2 ^ x1;
  assign a3 = x3;
  assign a4 = x4 ^ x3;

  assign b0 = a0 ^ (~a1 & a2);
  assign b1 = a1 ^ (~a2 & a3);
  assign b2 = a2 ^ (~a3 & a4);
  assign b3 = a3 ^ (~a4 & a0);
  assign b4 = a4 ^ (~a0 & a1);

  assign c0 = b0 ^ b4;
  assign c1 = b1 ^ b0;
  assign c2 = ~b2;
  assign c3 = b3 ^ b2;
  assign c4 = b4;

  assign d0 = c0 ^ ror64(c0, 19) ^ ror64(c0, 28);
  assign d1 = c1 ^ ror64(c1, 61) ^ ror64(c1, 39);
  assign d2 = c2 ^ ror64(c2, 1)  ^ ror64(c2, 6);
  assign d3 = c3 ^ ror64(c3, 10) ^ ror64(c3, 17);
  assign d4 = c4 ^ ror64(c4, 7)  ^ ror64(c4, 41);

  assign next_state = {d0, d1, d2, d3, d4};

endmodule

// File: rtl/ascon_perm_engine.sv
// Iterative ASCON-p engine answering round_start requests; ASCON_PERM_UNROLL2_EN chains two rounds per cycle.
module ascon_perm_engine
  import ascon_pkg::*;
(
  input logic                clk,
  input logic                rst,
  ascon_perm_engine_if.slave bus
);

  perm_state_t              state_q, state_d;
  logic [ASCON_STATE_W-1:0] data_q, data_d;
  logic [3:0]               idx_q, idx_d;
  logic [3:0]               left_q, left_d;
  logic [3:0]               n_sat;
  logic [ASCON_STATE_W-1:0] r1;

  assign n_sat = (bus.total_rounds > 4'(ASCON_MAX_ROUNDS)) ? 4'(ASCON_MAX_ROUNDS)
                                                            : bus.total_rounds;

  ascon_round_fn u_round1 (
    .state      (data_q),
    .rnd_idx    (idx_q),
    .next_state (r1)
  );

`ifdef ASCON_PERM_UNROLL2_EN
  logic [ASCON_STATE_W-1:0] r2;

  ascon_round_fn u_round2 (
    .state      (r1),
    .rnd_idx    (idx_q + 4'd1),
    .next_state (r2)
  );
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      left_q  <= left_d;
    end
  end

  // A request for zero rounds skips RUN and reports the untouched input.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    left_d  = left_q;
    unique case (state_q)
      IDLE: begin
        if (bus.round_start) begin
          data_d  = bus.state_in;
          idx_d   = 4'(ASCON_MAX_ROUNDS) - n_sat;
          left_d  = n_sat;
          state_d = (n_sat == 4'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (bus.enable) begin
`ifdef ASCON_PERM_UNROLL2_EN
          if (left_q >= 4'd2) begin
            data_d = r2;
            idx_d  = idx_q + 4'd2;
            left_d = left_q - 4'd2;
            if (left_q == 4'd2) state_d = DONE;
          end else begin
            data_d  = r1;
            idx_d   = idx_q + 4'd1;
            left_d  = left_q - 4'd1;
            state_d = DONE;
          end
`else
          data_d = r1;
          idx_d  = idx_q + 4'd1;
          left_d = left_q - 4'd1;
          if (left_q == 4'd1) state_d = DONE;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.state_out  = data_q;
  assign bus.busy       = (state_q == RUN);
  assign bus.round_done = (state_q == DONE);

endmodule

// File: tb/tb_ascon_perm_engine.sv
// Self-checking bench for ascon_perm_engine against a table-lookup ASCON reference model.
module tb_ascon_perm_engine;

  logic clk;
  logic rst;
  int   tests;
  int   failures;

  ascon_perm_engine_if bus ();

  ascon_perm_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  typedef struct {
    logic [319:0] st;
    logic [3:0]   n;
    int           stall_at;
    int           stall_len;
    logic [319:0] exp_st;
    int           exp_lat;
  } vec_t;

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  // Reference round works column by column through the S-box table.
  function automatic logic [319:0] ref_round(input logic [319:0] s, input int r);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  col;
    logic [4:0]  o;
    logic [7:0]  rc;
    for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
    rc = 8'(((15 - r) << 4) | r);
    x[2][7:0] = x[2][7:0] ^ rc;
    for (int b = 0; b < 64; b++) begin
      col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
      o   = SBOX[col];
      for (int i = 0; i < 5; i++) y[i][b] = o[4-i];
    end
    x[0] = y[0] ^ rotr(y[0], 19) ^ rotr(y[0], 28);
    x[1] = y[1] ^ rotr(y[1], 61) ^ rotr(y[1], 39);
    x[2] = y[2] ^ rotr(y[2], 1)  ^ rotr(y[2], 6);
    x[3] = y[3] ^ rotr(y[3], 10) ^ rotr(y[3], 17);
    x[4] = y[4] ^ rotr(y[4], 7)  ^ rotr(y[4], 41);
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic [319:0] ref_perm(input logic [319:0] s, input int n);
    int ns;
    ns = (n > 12) ? 12 : n;
    for (int r = 12 - ns; r < 12; r++) s = ref_round(s, r);
    return s;
  endfunction

  function automatic int run_len(input int n);
    int ns;
    ns = (n > 12) ? 12 : n;
`ifdef ASCON_PERM_UNROLL2_EN
    return (ns + 1) / 2;
`else
    return ns;
`endif
  endfunction

  function automatic int exp_latency(input int n, input int stalls);
    if (run_len(n) == 0) return 1;
    return run_len(n) + stalls + 1;
  endfunction

  function automatic logic [319:0] rand_state();
    logic [319:0] s;
    for (int w = 0; w < 10; w++) s[w*32 +: 32] = $urandom;
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [319:0] act, input logic [319:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int           cyc;
    int           lat;
    int           busy_cnt;
    int           overlap;
    logic [319:0] got;
    @(negedge clk);
    bus.state_in     = v.st;
    bus.total_rounds = v.n;
    bus.round_start  = 1'b1;
    bus.enable       = 1'b1;
    @(posedge clk);
    #1;
    bus.round_start = 1'b0;
    cyc = 1; lat = 0; busy_cnt = 0; overlap = 0; got = '0;
    while (lat == 0 && cyc <= 60) begin
      @(negedge clk);
      bus.enable = !(v.stall_len > 0 && cyc >= v.stall_at && cyc < v.stall_at + v.stall_len);
      if (bus.busy && bus.round_done) overlap++;
      if (bus.busy) busy_cnt++;
      if (bus.round_done) begin
        lat = cyc;
        got = bus.state_out;
      end
      cyc++;
    end
    bus.enable = 1'b1;
    checkOutput({tag, " latency"}, 320'(lat), 320'(v.exp_lat));
    checkOutput({tag, " state"}, got, v.exp_st);
    checkOutput({tag, " busy cycles"}, 320'(busy_cnt), 320'(v.exp_lat - 1));
    checkOutput({tag, " busy/done overlap"}, 320'(overlap), 320'(0));
    @(negedge clk);
    checkOutput({tag, " idle hold"}, bus.state_out, v.exp_st);
  endtask

  vec_t         vecs [14];
  logic [319:0] init_st;
  logic [319:0] s;
  logic [319:0] st1;
  logic [319:0] st2;
  int           d1;
  int           d2;
  int           cnt;
  int           cyc;

  initial begin
    tests = 0;
    failures = 0;
    rst = 1'b0;
    bus.round_start  = 1'b0;
    bus.enable       = 1'b1;
    bus.total_rounds = 4'd0;
    bus.state_in     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset busy", 320'(bus.busy), 320'(0));
    checkOutput("reset round_done", 320'(bus.round_done), 320'(0));
    checkOutput("reset state_out", bus.state_out, '0);
    rst = 1'b1;

    init_st = {64'h80400C0600000000, 64'h0001020304050607, 64'h08090A0B0C0D0E0F,
               64'h0001020304050607, 64'h08090A0B0C0D0E0F};
    vecs[0] = '{st: '0, n: 4'd12, stall_at: 0, stall_len: 0, exp_st: '0, exp_lat: 0};
    vecs[1] = '{st: init_st, n: 4'd12, stall_at: 0, stall_len: 0, exp_st: '0, exp_lat: 0};
    vecs[3] = '{st: '0, n: 4'd12, stall_at: 3, stall_len: 3, exp_st: '0, exp_lat: 0};
    vecs[4] = '{st: rand_state(), n: 4'd0, stall_at: 0, stall_len: 0, exp_st: '0, exp_lat: 0};
    vecs[5] = '{st: init_st, n: 4'd15, stall_at: 0, stall_len: 0, exp_st: '0, exp_lat: 0};
    for (int i = 0; i < 14; i++) begin
      if (i == 2) begin
        vecs[2] = '{st: vecs[1].exp_st, n: 4'd6, stall_at: 0, stall_len: 0, exp_st: '0, exp_lat: 0};
      end else if (i >= 6) begin
        vecs[i].st        = rand_state();
        vecs[i].n         = 4'($urandom_range(0, 15));
        vecs[i].stall_at  = 1;
        vecs[i].stall_len = (run_len(int'(vecs[i].n)) > 0) ? int'($urandom_range(0, 2)) : 0;
      end
      vecs[i].exp_st  = ref_perm(vecs[i].st, int'(vecs[i].n));
      vecs[i].exp_lat = exp_latency(int'(vecs[i].n), vecs[i].stall_len);
    end
    checkOutput("p12 equals p15 result", vecs[5].exp_st, vecs[1].exp_st);
    checkOutput("N=0 passthrough model", vecs[4].exp_st, vecs[4].st);

    for (int i = 0; i < 14; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // round_start held high: back-to-back accepts with IDLE gap, same input
    s = rand_state();
    @(negedge clk);
    bus.state_in = s; bus.total_rounds = 4'd5; bus.round_start = 1'b1;
    @(posedge clk);
    cnt = 0; d1 = 0; d2 = 0; st1 = '0; st2 = '0; cyc = 1;
    while (cnt < 2 && cyc <= 60) begin
      @(negedge clk);
      if (bus.round_done) begin
        cnt++;
        if (cnt == 1) begin d1 = cyc; st1 = bus.state_out; end
        else begin d2 = cyc; st2 = bus.state_out; bus.round_start = 1'b0; end
      end
      cyc++;
    end
    bus.round_start = 1'b0;
    checkOutput("held first done cycle", 320'(d1), 320'(run_len(5) + 1));
    checkOutput("held second done cycle", 320'(d2), 320'(2 * run_len(5) + 3));
    checkOutput("held first state", st1, ref_perm(s, 5));
    checkOutput("held second state", st2, ref_perm(s, 5));

    // pulse during RUN with different inputs must be ignored
    s = rand_state();
    @(negedge clk);
    bus.state_in = s; bus.total_rounds = 4'd8; bus.round_start = 1'b1;
    @(posedge clk);
    #1 bus.round_start = 1'b0;
    d1 = 0; st1 = '0;
    for (int c = 1; c <= 40 && d1 == 0; c++) begin
      @(negedge clk);
      bus.round_start  = (c == 2);
      bus.state_in     = (c == 2) ? ~s : s;
      bus.total_rounds = (c == 2) ? 4'd3 : 4'd8;
      if (bus.round_done) begin d1 = c; st1 = bus.state_out; end
    end
    bus.round_start = 1'b0;
    checkOutput("ignored pulse done cycle", 320'(d1), 320'(exp_latency(8, 0)));
    checkOutput("ignored pulse state", st1, ref_perm(s, 8));
    @(negedge clk);
    checkOutput("ignored pulse no restart", 320'(bus.busy), 320'(0));

    // synchronous reset in cycle 5 of a 12-round run
    s = rand_state();
    @(negedge clk);
    bus.state_in = s; bus.total_rounds = 4'd12; bus.round_start = 1'b1;
    @(posedge clk);
    #1 bus.round_start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort busy", 320'(bus.busy), 320'(0));
    checkOutput("abort round_done", 320'(bus.round_done), 320'(0));
    checkOutput("abort state_out", bus.state_out, '0);
    rst = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.round_done || bus.busy) cnt++;
    end
    checkOutput("abort no late done", 320'(cnt), 320'(0));

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
